comparator_triad_decoder: RTL and testbench

Decodes the serial comparator triads arriving on the 48 buffered distrip lines (6 layers × 8 distrips) into a 6 × 32 half-strip hit image with programmable persistence. Sits directly downstream of the comparator I/O buffer stage: it consumes the buffered G1C..G6C buses and feeds the half-strip image to the pattern-finding logic. It runs on the same LCT clock that is driven out to the comparator ASICs.

---
 rtl/comparator_triad_decoder.sv | 162 ++++++++++++++++
 tb/tb_comparator_triad_decoder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_triad_decoder.sv
// ============================================================================
//  Module   : comparator_triad_decoder
//  Purpose  : Decodes serial comparator triads (start, hs, strip) arriving on
//             48 buffered distrip lines (6 layers x 8 distrips) into a
//             6 x 32 half-strip hit image with programmable persistence.
//  Revision : 1.0  initial release
//
//  Ports
//    LCT_CLK      in   1   LCT clock, all state on rising edge
//    LCT_RST_B    in   1   asynchronous active-low reset
//    G1C..G6C     in   8   triad lines per layer, bit d = distrip d
//    TRIAD_ENA    in   1   synchronous decoder enable
//    HS1..HS6     out  32  registered half-strip image per layer
//    LAYER_HIT    out  6   bit L-1 = OR of HSL
//    OVERLAP_CNT  out  16  saturating overlap counter (TRIAD_ERR_CNT_EN only)
//
//  Parameter
//    PERSIST      half-strip hold time in LCT clocks, legal 1..15
//
//  Build option
//    TRIAD_ERR_CNT_EN  when defined, builds the OVERLAP_CNT port and counter
// ============================================================================
`default_nettype none

module comparator_triad_decoder #(
  parameter int PERSIST = 6
) (
  input  logic        LCT_CLK,
  input  logic        LCT_RST_B,
  input  logic [7:0]  G1C,
  input  logic [7:0]  G2C,
  input  logic [7:0]  G3C,
  input  logic [7:0]  G4C,
  input  logic [7:0]  G5C,
  input  logic [7:0]  G6C,
  input  logic        TRIAD_ENA,
  output logic [31:0] HS1,
  output logic [31:0] HS2,
  output logic [31:0] HS3,
  output logic [31:0] HS4,
  output logic [31:0] HS5,
  output logic [31:0] HS6,
`ifdef TRIAD_ERR_CNT_EN
  output logic [15:0] OVERLAP_CNT,
`endif
  output logic [5:0]  LAYER_HIT
);

  localparam int         NCH       = 48;
  localparam logic [3:0] c_PERSIST = 4'(PERSIST);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_S1   = 2'd1,
    ST_S2   = 2'd2
  } state_t;

  // Channel index = 8*(layer-1) + distrip
  logic [NCH-1:0]      w_g;
  logic [NCH-1:0]      r_iq;
  logic [NCH-1:0][3:0] w_field;

  assign w_g = {G6C, G5C, G4C, G3C, G2C, G1C};

  always_ff @(posedge LCT_CLK or negedge LCT_RST_B) begin
    if (!LCT_RST_B) r_iq <= '0;
    else            r_iq <= w_g;
  end

`ifdef TRIAD_ERR_CNT_EN
  logic [NCH-1:0] w_ovl;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      state_t     r_state;
      state_t     w_state_nxt;
      logic       w_done;
      logic       r_hs;
      logic [3:0] r_pc;
      logic [3:0] r_field;
      logic [3:0] w_onehot;

      always_ff @(posedge LCT_CLK or negedge LCT_RST_B) begin
        if (!LCT_RST_B) r_state <= ST_IDLE;
        else            r_state <= w_state_nxt;
      end

      // Disabled decoder drops any partial triad by returning to IDLE.
      always_comb begin
        w_state_nxt = ST_IDLE;
        w_done      = 1'b0;
        if (TRIAD_ENA) begin
          case (r_state)
            ST_IDLE: w_state_nxt = r_iq[gi] ? ST_S1 : ST_IDLE;
            ST_S1:   w_state_nxt = ST_S2;
            ST_S2: begin
              w_state_nxt = ST_IDLE;
              w_done      = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
          endcase
        end
      end

      // Bit position within the 4-bit field is 2*strip + hs.
      assign w_onehot = 4'b0001 << {r_iq[gi], r_hs};

      always_ff @(posedge LCT_CLK or negedge LCT_RST_B) begin
        if (!LCT_RST_B) begin
          r_hs    <= 1'b0;
          r_pc    <= 4'd0;
          r_field <= 4'd0;
        end else begin
          if (r_state == ST_S1) r_hs <= r_iq[gi];
          if (w_done) begin
            // A new hit replaces any persisting one and restarts the hold.
            r_pc    <= c_PERSIST;
            r_field <= w_onehot;
          end else if (r_pc != 4'd0) begin
            r_pc <= r_pc - 4'd1;
            if (r_pc == 4'd1) r_field <= 4'd0;
          end
        end
      end

      assign w_field[gi] = r_field;

`ifdef TRIAD_ERR_CNT_EN
      assign w_ovl[gi] = w_done && (r_pc != 4'd0);
`endif
    end
  endgenerate

  assign HS1 = w_field[7:0];
  assign HS2 = w_field[15:8];
  assign HS3 = w_field[23:16];
  assign HS4 = w_field[31:24];
  assign HS5 = w_field[39:32];
  assign HS6 = w_field[47:40];

  assign LAYER_HIT = {|HS6, |HS5, |HS4, |HS3, |HS2, |HS1};

`ifdef TRIAD_ERR_CNT_EN
  logic [15:0] r_ovl_cnt;

  // Counts cycles with at least one overlap, not individual overlaps.
  always_ff @(posedge LCT_CLK or negedge LCT_RST_B) begin
    if (!LCT_RST_B) begin
      r_ovl_cnt <= 16'd0;
    end else if ((|w_ovl) && (r_ovl_cnt != 16'hFFFF)) begin
      r_ovl_cnt <= r_ovl_cnt + 16'd1;
    end
  end

  assign OVERLAP_CNT = r_ovl_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_comparator_triad_decoder.sv
`default_nettype none

module tb_comparator_triad_decoder;

  localparam int PERSIST = 6;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena   = 1'b0;
  logic [7:0]  g [6];
  logic [31:0] hs1, hs2, hs3, hs4, hs5, hs6;
  logic [31:0] hs_a [6];
  logic [5:0]  layer_hit;
`ifdef TRIAD_ERR_CNT_EN
  logic [15:0] ovl_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  comparator_triad_decoder #(.PERSIST(PERSIST)) dut (
    .LCT_CLK     (clk),
    .LCT_RST_B   (rst_n),
    .G1C         (g[0]),
    .G2C         (g[1]),
    .G3C         (g[2]),
    .G4C         (g[3]),
    .G5C         (g[4]),
    .G6C         (g[5]),
    .TRIAD_ENA   (ena),
    .HS1         (hs1),
    .HS2         (hs2),
    .HS3         (hs3),
    .HS4         (hs4),
    .HS5         (hs5),
    .HS6         (hs6),
`ifdef TRIAD_ERR_CNT_EN
    .OVERLAP_CNT (ovl_cnt),
`endif
    .LAYER_HIT   (layer_hit)
  );

  assign hs_a[0] = hs1;
  assign hs_a[1] = hs2;
  assign hs_a[2] = hs3;
  assign hs_a[3] = hs4;
  assign hs_a[4] = hs5;
  assign hs_a[5] = hs6;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: time-stamped frames. A frame starts when a 1 was on the
  // pin at edge k and the channel was free; it completes 3 edges later using
  // the pin values of edges k+1 (hs) and k+2 (strip). A hit is visible while
  // fewer than PERSIST edges have elapsed since its completion.
  // ---------------------------------------------------------------------------
  int         n_edge = 0;
  int         fs        [48];   // pin edge of the start bit, -1 when free
  logic [3:0] hist      [48];   // hist[i] = pin value i edges ago
  int         last_done [48];
  int         last_pos  [48];
  int         exp_cnt;

  task automatic model_reset();
    for (int c = 0; c < 48; c++) begin
      fs[c]        = -1;
      hist[c]      = 4'd0;
      last_done[c] = -100000;
      last_pos[c]  = 0;
    end
    exp_cnt = 0;
  endtask

  initial model_reset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      bit any_ovl;
      any_ovl = 1'b0;
      n_edge++;
      for (int c = 0; c < 48; c++) begin
        hist[c] = {hist[c][2:0], g[c/8][c%8]};
        if (fs[c] >= 0) begin
          if (!ena) begin
            fs[c] = -1;
          end else if (n_edge - fs[c] == 3) begin
            if ((n_edge - 1 - last_done[c]) < PERSIST) any_ovl = 1'b1;
            last_done[c] = n_edge;
            last_pos[c]  = 2 * int'(hist[c][1]) + int'(hist[c][2]);
            fs[c]        = -1;
          end
        end else if (ena && hist[c][1]) begin
          fs[c] = n_edge - 1;
        end
      end
      if (any_ovl && exp_cnt != 65535) exp_cnt++;
    end
  end

  function automatic logic [31:0] exp_hs(input int layer);
    logic [31:0] v;
    v = 32'd0;
    for (int d = 0; d < 8; d++) begin
      int c;
      c = layer * 8 + d;
      if ((n_edge - last_done[c]) < PERSIST) v[4*d + last_pos[c]] = 1'b1;
    end
    return v;
  endfunction

  // Cycle-by-cycle comparison against the model.
  always @(posedge clk) begin
    logic [5:0] lh;
    #1;
    lh = 6'd0;
    for (int l = 0; l < 6; l++) begin
      check($sformatf("model_hs%0d", l + 1), hs_a[l], exp_hs(l));
      lh[l] = |exp_hs(l);
    end
    check("model_layer_hit", {26'd0, layer_hit}, {26'd0, lh});
`ifdef TRIAD_ERR_CNT_EN
    check("model_ovl_cnt", {16'd0, ovl_cnt}, exp_cnt);
`endif
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    for (int l = 0; l < 6; l++) g[l] = 8'h00;
    repeat (n) @(negedge clk);
  endtask

  initial begin
`ifdef TRIAD_ERR_CNT_EN
    logic [15:0] cnt0;
`endif
    bit seq2 [8];
    seq2 = '{1, 0, 1, 1, 1, 0, 0, 0};
    for (int l = 0; l < 6; l++) g[l] = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_hs1", hs1, 32'd0);
    check("reset_hs6", hs6, 32'd0);
    check("reset_layer_hit", {26'd0, layer_hit}, 32'd0);
    rst_n = 1'b1;
    ena   = 1'b1;
    idle(3);

    // Single triad on G3C[5]: 1,1,0 -> HS3[21] for exactly PERSIST clocks.
    g[2][5] = 1'b1; @(negedge clk);
    g[2][5] = 1'b1; @(negedge clk);
    g[2][5] = 1'b0; @(negedge clk);
    @(negedge clk);
    check("single_hs3", hs3, 32'h0020_0000);
    check("single_others", hs1 | hs2 | hs4 | hs5 | hs6, 32'd0);
    check("single_layer_hit", {26'd0, layer_hit}, 32'h0000_0004);
    repeat (5) begin
      @(negedge clk);
      check("single_hold_hs3", hs3, 32'h0020_0000);
    end
    @(negedge clk);
    check("single_clear_hs3", hs3, 32'd0);
    idle(4);

    // Back-to-back triads on G1C[0]: HS1[2] then HS1[1] with an overlap.
`ifdef TRIAD_ERR_CNT_EN
    cnt0 = ovl_cnt;
`endif
    for (int i = 0; i < 8; i++) begin
      g[0][0] = seq2[i];
      @(negedge clk);
      if (i == 3 || i == 5) check("b2b_first_hs1", hs1, 32'h0000_0004);
      if (i == 6) begin
        check("b2b_second_hs1", hs1, 32'h0000_0002);
`ifdef TRIAD_ERR_CNT_EN
        check("b2b_ovl_cnt", {16'd0, ovl_cnt}, {16'd0, cnt0 + 16'd1});
`endif
      end
    end
    idle(10);

    // All 48 lines 1,1,1 together -> every field reports bit 3.
    for (int i = 0; i < 3; i++) begin
      for (int l = 0; l < 6; l++) g[l] = 8'hFF;
      @(negedge clk);
    end
    for (int l = 0; l < 6; l++) g[l] = 8'h00;
    @(negedge clk);
    for (int l = 0; l < 6; l++) check($sformatf("all_hs%0d", l + 1), hs_a[l], 32'h8888_8888);
    check("all_layer_hit", {26'd0, layer_hit}, 32'h0000_003F);
    idle(10);

    // Enable dropped mid-triad on G6C[7], then a clean 1,0,0 triad.
    g[5][7] = 1'b1; @(negedge clk);
    g[5][7] = 1'b1; @(negedge clk);
    g[5][7] = 1'b1; ena = 1'b0; @(negedge clk);
    g[5][7] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("ena_drop_hs6", hs6, 32'd0);
    end
    ena = 1'b1;
    repeat (3) @(negedge clk);
    check("ena_reenable_hs6", hs6, 32'd0);
    g[5][7] = 1'b1; @(negedge clk);
    g[5][7] = 1'b0; @(negedge clk);
    g[5][7] = 1'b0; @(negedge clk);
    @(negedge clk);
    check("ena_fresh_hs6", hs6, 32'h1000_0000);
    idle(10);

    // Asynchronous reset while HS2[9] persists and G4C[0] sits in S1.
    g[1][2] = 1'b1; @(negedge clk);
    g[1][2] = 1'b1; @(negedge clk);
    g[1][2] = 1'b0; @(negedge clk);
    @(negedge clk);
    check("rst_pre_hs2", hs2, 32'h0000_0200);
    g[3][0] = 1'b1; @(negedge clk);
    g[3][0] = 1'b0; @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_hs", hs1 | hs2 | hs3 | hs4 | hs5 | hs6, 32'd0);
    check("async_rst_layer_hit", {26'd0, layer_hit}, 32'd0);
`ifdef TRIAD_ERR_CNT_EN
    check("async_rst_ovl_cnt", {16'd0, ovl_cnt}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_hs", hs1 | hs2 | hs3 | hs4 | hs5 | hs6, 32'd0);

    // Randomized traffic checked every cycle by the model.
    for (int i = 0; i < 2000; i++) begin
      for (int l = 0; l < 6; l++) g[l] = 8'($urandom & $urandom);
      ena = ($urandom_range(0, 15) != 0);
      @(negedge clk);
    end
    ena = 1'b1;
    idle(10);

`ifdef TRIAD_ERR_CNT_EN
    // Three staggered continuous streams give an overlap on every cycle.
    g[0][0] = 1'b1; @(negedge clk);
    g[0][1] = 1'b1; @(negedge clk);
    g[0][2] = 1'b1;
    repeat (65600) @(negedge clk);
    check("sat_ovl_cnt", {16'd0, ovl_cnt}, 32'h0000_FFFF);
    repeat (5) @(negedge clk);
    check("sat_hold_ovl_cnt", {16'd0, ovl_cnt}, 32'h0000_FFFF);
    idle(10);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
